// File: rtl/rs232_pkg.sv
// Shared definitions for the rs232 receive path (rs232in, rs232in_fifo, rs232).
package rs232_pkg;

  localparam int BYTE_W             = 8;
  localparam int DEFAULT_DEPTH_LOG2 = 4;

  typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/fifo_ram.sv
// Storage for the rs232 receive FIFO: one write port, one asynchronous read port.
// There is no reset, so the array can map onto distributed RAM.
module fifo_ram #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rs232in_fifo.sv
// First-word-fall-through receive buffer between rs232in and the rs232 peripheral.
// Optional saturating dropped-byte counter: define RS232IN_FIFO_DROPCOUNT_EN.
module rs232in_fifo
  import rs232_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  rs232in_attention,
  input  byte_t                 rs232in_data,
  input  logic                  rd,
  output byte_t                 rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  overrun,
  input  logic                  clear_overrun,
  output logic [DROP_CNT_W-1:0] dropped
);

  localparam int PTR_W = DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2**DEPTH_LOG2);

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             push;
  logic             pop;
  logic             drop;

  // A pop frees the slot, so a full FIFO still accepts a byte in a pop cycle.
  assign rd_valid = (count != '0);
  assign full     = (count == DEPTH);
  assign pop      = rd && rd_valid;
  assign push     = rs232in_attention && (!full || pop);
  assign drop     = rs232in_attention && full && !pop;

  fifo_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (BYTE_W)
  ) u_ram (
    .clock (clock),
    .we    (push && !rst),
    .waddr (wptr),
    .wdata (rs232in_data),
    .raddr (rptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clock) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A drop in the clearing cycle must stay visible to software.
      if (drop)               overrun <= 1'b1;
      else if (clear_overrun) overrun <= 1'b0;
    end
  end

`ifdef RS232IN_FIFO_DROPCOUNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt;

  always_ff @(posedge clock) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (clear_overrun) begin
      drop_cnt <= drop ? DROP_CNT_W'(1) : '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end

  assign dropped = drop_cnt;
`else
  assign dropped = '0;
`endif

endmodule

// File: tb/tb_rs232in_fifo.sv
// Directed self-checking bench for rs232in_fifo; expected dropped counts follow
// whether RS232IN_FIFO_DROPCOUNT_EN is defined for the build.
module tb_rs232in_fifo;

  logic        clock;
  logic        rst;
  logic        rs232in_attention;
  logic [7:0]  rs232in_data;
  logic        rd;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [4:0]  count;
  logic        full;
  logic        overrun;
  logic        clear_overrun;
  logic [15:0] dropped;

  int vectors = 0;
  int miscompares = 0;

`ifdef RS232IN_FIFO_DROPCOUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  rs232in_fifo #(
    .DEPTH_LOG2 (4),
    .DROP_CNT_W (16)
  ) dut (
    .clock             (clock),
    .rst               (rst),
    .rs232in_attention (rs232in_attention),
    .rs232in_data      (rs232in_data),
    .rd                (rd),
    .rd_data           (rd_data),
    .rd_valid          (rd_valid),
    .count             (count),
    .full              (full),
    .overrun           (overrun),
    .clear_overrun     (clear_overrun),
    .dropped           (dropped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one clock of stimulus; outputs are observed 1ns after the edge.
  task automatic cycle(input logic att, input logic [7:0] d, input logic r,
                       input logic clr, input logic rs = 1'b0);
    rs232in_attention = att;
    rs232in_data      = d;
    rd                = r;
    clear_overrun     = clr;
    rst               = rs;
    @(posedge clock);
    #1;
    rs232in_attention = 1'b0;
    rd                = 1'b0;
    clear_overrun     = 1'b0;
    rst               = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    vectors++;
    if ({rd_valid, count, full, overrun, dropped} !== {1'b0, 5'd0, 1'b0, 1'b0, 16'd0}) begin
      miscompares++;
      $display("[TB] FAIL reset_state got v=%b c=%0d f=%b o=%b d=%0d exp 0/0/0/0/0",
               rd_valid, count, full, overrun, dropped);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp;
    cycle(1'b1, 8'h41, 1'b0, 1'b0);
    vectors++;
    if ({rd_valid, rd_data} !== {1'b1, 8'h41}) begin
      miscompares++;
      $display("[TB] FAIL fwft_first got v=%b d=%h exp v=1 d=41", rd_valid, rd_data);
    end
    cycle(1'b1, 8'h42, 1'b0, 1'b0);
    cycle(1'b1, 8'h43, 1'b0, 1'b0);
    vectors++;
    if (count !== 5'd3) begin
      miscompares++;
      $display("[TB] FAIL basic_count got %0d exp 3", count);
    end
    for (int i = 0; i < 3; i++) begin
      exp = 8'h41 + 8'(i);
      vectors++;
      if ({rd_valid, rd_data} !== {1'b1, exp}) begin
        miscompares++;
        $display("[TB] FAIL basic_pop%0d got v=%b d=%h exp v=1 d=%h", i, rd_valid, rd_data, exp);
      end
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    vectors++;
    if ({rd_valid, count} !== {1'b0, 5'd0}) begin
      miscompares++;
      $display("[TB] FAIL basic_empty got v=%b c=%0d exp v=0 c=0", rd_valid, count);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    vectors++;
    if ({full, count, overrun} !== {1'b1, 5'd16, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL fill16 got f=%b c=%0d o=%b exp f=1 c=16 o=0", full, count, overrun);
    end
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    vectors++;
    if ({full, count, overrun, dropped} !== {1'b1, 5'd16, 1'b1, 16'(CNT_ON)}) begin
      miscompares++;
      $display("[TB] FAIL drop_aa got f=%b c=%0d o=%b d=%0d exp f=1 c=16 o=1 d=%0d",
               full, count, overrun, dropped, CNT_ON);
    end
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if ({rd_valid, rd_data} !== {1'b1, 8'(i)}) begin
        miscompares++;
        $display("[TB] FAIL drain%0d got v=%b d=%h exp v=1 d=%h", i, rd_valid, rd_data, 8'(i));
      end
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    vectors++;
    if ({rd_valid, overrun, dropped} !== {1'b0, 1'b0, 16'd0}) begin
      miscompares++;
      $display("[TB] FAIL clear_after_drain got v=%b o=%b d=%0d exp 0/0/0", rd_valid, overrun, dropped);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    vectors++;
    if ({count, full, overrun, rd_data} !== {5'd16, 1'b1, 1'b0, 8'h01}) begin
      miscompares++;
      $display("[TB] FAIL full_pushpop got c=%0d f=%b o=%b d=%h exp c=16 f=1 o=0 d=01",
               count, full, overrun, rd_data);
    end
    for (int i = 0; i < 16; i++) begin
      exp = (i == 15) ? 8'h55 : 8'(i + 1);
      vectors++;
      if ({rd_valid, rd_data} !== {1'b1, exp}) begin
        miscompares++;
        $display("[TB] FAIL full_drain%0d got v=%b d=%h exp v=1 d=%h", i, rd_valid, rd_data, exp);
      end
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  task automatic test_empty_push_pop();
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    vectors++;
    if ({rd_valid, count, rd_data} !== {1'b1, 5'd1, 8'h77}) begin
      miscompares++;
      $display("[TB] FAIL empty_pushpop got v=%b c=%0d d=%h exp v=1 c=1 d=77", rd_valid, count, rd_data);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    vectors++;
    if ({rd_valid, count} !== {1'b0, 5'd0}) begin
      miscompares++;
      $display("[TB] FAIL empty_rd got v=%b c=%0d exp v=0 c=0", rd_valid, count);
    end
    cycle(1'b1, 8'h12, 1'b0, 1'b0);
    vectors++;
    if ({rd_valid, count, rd_data} !== {1'b1, 5'd1, 8'h12}) begin
      miscompares++;
      $display("[TB] FAIL empty_rd_noptr got v=%b c=%0d d=%h exp v=1 c=1 d=12", rd_valid, count, rd_data);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    logic [7:0] exp;
    q.push_back(8'h80);
    cycle(1'b1, 8'h80, 1'b0, 1'b0);
    q.push_back(8'h81);
    cycle(1'b1, 8'h81, 1'b0, 1'b0);
    for (int i = 2; i < 40; i++) begin
      exp = q.pop_front();
      vectors++;
      if ({rd_valid, rd_data, count} !== {1'b1, exp, 5'd2}) begin
        miscompares++;
        $display("[TB] FAIL wrap%0d got v=%b d=%h c=%0d exp v=1 d=%h c=2", i, rd_valid, rd_data, count, exp);
      end
      q.push_back(8'h80 + 8'(i));
      cycle(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0);
    end
    while (q.size() > 0) begin
      exp = q.pop_front();
      vectors++;
      if ({rd_valid, rd_data} !== {1'b1, exp}) begin
        miscompares++;
        $display("[TB] FAIL wrap_tail got v=%b d=%h exp v=1 d=%h", rd_valid, rd_data, exp);
      end
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  task automatic test_overrun_ctrl();
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    cycle(1'b1, 8'hEF, 1'b0, 1'b1);
    vectors++;
    if ({overrun, dropped} !== {1'b1, 16'(CNT_ON)}) begin
      miscompares++;
      $display("[TB] FAIL clear_with_drop got o=%b d=%0d exp o=1 d=%0d", overrun, dropped, CNT_ON);
    end
    cycle(1'b1, 8'hF0, 1'b0, 1'b0);
    vectors++;
    if (dropped !== 16'(2 * CNT_ON)) begin
      miscompares++;
      $display("[TB] FAIL drop_count2 got %0d exp %0d", dropped, 2 * CNT_ON);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    vectors++;
    if ({overrun, dropped, count} !== {1'b0, 16'd0, 5'd16}) begin
      miscompares++;
      $display("[TB] FAIL clear_alone got o=%b d=%0d c=%0d exp o=0 d=0 c=16", overrun, dropped, count);
    end
    cycle(1'b1, 8'hF1, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    vectors++;
    if ({count, overrun, rd_data} !== {5'd5, 1'b1, 8'h2B}) begin
      miscompares++;
      $display("[TB] FAIL pre_reset got c=%0d o=%b d=%h exp c=5 o=1 d=2b", count, overrun, rd_data);
    end
    cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    vectors++;
    if ({count, rd_valid, overrun, full, dropped} !== {5'd0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      miscompares++;
      $display("[TB] FAIL mid_reset got c=%0d v=%b o=%b f=%b d=%0d exp 0/0/0/0/0",
               count, rd_valid, overrun, full, dropped);
    end
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    vectors++;
    if ({count, rd_data} !== {5'd1, 8'h3C}) begin
      miscompares++;
      $display("[TB] FAIL post_reset got c=%0d d=%h exp c=1 d=3c", count, rd_data);
    end
  endtask

  initial begin
    rst               = 1'b1;
    rs232in_attention = 1'b0;
    rs232in_data      = 8'h00;
    rd                = 1'b0;
    clear_overrun     = 1'b0;
    @(posedge clock);
    #1;
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_wrap();
    test_overrun_ctrl();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
